// File: rtl/axi4_lite_initiator.sv
// axi4_lite_initiator: single-outstanding AXI4-Lite master that turns one-cycle
// simple-bus write/read requests into full AXI4-Lite transactions and reports
// completion with a one-cycle response pulse.
module axi4_lite_initiator #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmdWr,
    input  logic                              cmdRd,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmdAddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmdWrData,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmdWstrb,
    output logic                              cmdReady,
    output logic                              rspValid,
    output logic                              rspIsRead,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rspRdData,
    output logic [1:0]                        rspResp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wData;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] r_wStrb;
    logic                            r_awValid;
    logic                            r_wValid;
    logic                            r_arValid;
    logic                            r_awDone;
    logic                            r_wDone;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rspRdData;
    logic [1:0]                      r_rspResp;
    logic                            r_rspIsRead;

    logic w_awHs;
    logic w_wHs;
    logic w_arHs;
    logic w_acceptWr;
    logic w_acceptRd;
    logic w_cmdReady;
    logic w_bReady;
    logic w_rReady;
    logic w_rspValid;

    assign w_awHs = r_awValid & M_AXI_AWREADY;
    assign w_wHs  = r_wValid  & M_AXI_WREADY;
    assign w_arHs = r_arValid & M_AXI_ARREADY;

    // Next-state selection plus the state-decoded handshake and status outputs
    always_comb begin
        w_nextState = r_state;
        w_cmdReady  = 1'b0;
        w_bReady    = 1'b0;
        w_rReady    = 1'b0;
        w_rspValid  = 1'b0;
        w_acceptWr  = 1'b0;
        w_acceptRd  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmdReady = 1'b1;
                if (cmdWr) begin
                    w_acceptWr  = 1'b1;
                    w_nextState = WR_REQ;
                end else if (cmdRd) begin
                    w_acceptRd  = 1'b1;
                    w_nextState = RD_REQ;
                end
            end
            WR_REQ: begin
                if ((r_awDone | w_awHs) && (r_wDone | w_wHs)) begin
                    w_nextState = WR_RESP;
                end
            end
            WR_RESP: begin
                w_bReady = 1'b1;
                if (M_AXI_BVALID) begin
                    w_nextState = DONE;
                end
            end
            RD_REQ: begin
                if (w_arHs) begin
                    w_nextState = RD_RESP;
                end
            end
            RD_RESP: begin
                w_rReady = 1'b1;
                if (M_AXI_RVALID) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_rspValid  = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request channels: latch the command on accept, hold VALIDs until each handshake
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_addr    <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
            r_awValid <= 1'b0;
            r_wValid  <= 1'b0;
            r_arValid <= 1'b0;
            r_awDone  <= 1'b0;
            r_wDone   <= 1'b0;
        end else if (w_acceptWr) begin
            r_addr    <= cmdAddr;
            r_wData   <= cmdWrData;
            r_wStrb   <= cmdWstrb;
            r_awValid <= 1'b1;
            r_wValid  <= 1'b1;
            r_awDone  <= 1'b0;
            r_wDone   <= 1'b0;
        end else if (w_acceptRd) begin
            r_addr    <= cmdAddr;
            r_arValid <= 1'b1;
        end else begin
            if (w_awHs) begin
                r_awValid <= 1'b0;
                r_awDone  <= 1'b1;
            end
            if (w_wHs) begin
                r_wValid <= 1'b0;
                r_wDone  <= 1'b1;
            end
            if (w_arHs) begin
                r_arValid <= 1'b0;
            end
        end
    end

    // Response capture; values persist until the next completed transaction
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_rspRdData <= '0;
            r_rspResp   <= 2'b00;
            r_rspIsRead <= 1'b0;
        end else if (r_state == WR_RESP && M_AXI_BVALID) begin
            r_rspRdData <= '0;
            r_rspResp   <= M_AXI_BRESP;
            r_rspIsRead <= 1'b0;
        end else if (r_state == RD_RESP && M_AXI_RVALID) begin
            r_rspRdData <= M_AXI_RDATA;
            r_rspResp   <= M_AXI_RRESP;
            r_rspIsRead <= 1'b1;
        end
    end

    assign cmdReady      = w_cmdReady;
    assign rspValid      = w_rspValid;
    assign rspIsRead     = r_rspIsRead;
    assign rspRdData     = r_rspRdData;
    assign rspResp       = r_rspResp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awValid;
    assign M_AXI_WDATA   = r_wData;
    assign M_AXI_WSTRB   = r_wStrb;
    assign M_AXI_WVALID  = r_wValid;
    assign M_AXI_BREADY  = w_bReady;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arValid;
    assign M_AXI_RREADY  = w_rReady;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// tb_axi4_lite_initiator: directed bench for axi4_lite_initiator. Table vectors
// cover minimum-latency writes/reads; hand sequences cover stalls, collisions,
// busy commands and mid-transaction reset. Samples and drives on the falling edge.
`timescale 1ns/1ps
module tb_axi4_lite_initiator;

    logic        clk;
    logic        aresetn;
    logic        cmdWr;
    logic        cmdRd;
    logic [5:0]  cmdAddr;
    logic [31:0] cmdWrData;
    logic [3:0]  cmdWstrb;
    logic        cmdReady;
    logic        rspValid;
    logic        rspIsRead;
    logic [31:0] rspRdData;
    logic [1:0]  rspResp;
    logic [5:0]  awAddr;
    logic        awValid;
    logic        awReady;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic        wValid;
    logic        wReady;
    logic [1:0]  bResp;
    logic        bValid;
    logic        bReady;
    logic [5:0]  arAddr;
    logic        arValid;
    logic        arReady;
    logic [31:0] rData;
    logic [1:0]  rResp;
    logic        rValid;
    logic        rReady;

    int errors = 0;
    int checks = 0;
    int rspCount = 0;
    int arCount = 0;

    typedef struct {
        logic        isWrite;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] expRdData;
        logic [1:0]  expResp;
        logic        expIsRead;
    } vec_t;

    vec_t vecs[5];

    axi4_lite_initiator #(
        .C_M_AXI_ADDR_WIDTH(6),
        .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (aresetn),
        .cmdWr         (cmdWr),
        .cmdRd         (cmdRd),
        .cmdAddr       (cmdAddr),
        .cmdWrData     (cmdWrData),
        .cmdWstrb      (cmdWstrb),
        .cmdReady      (cmdReady),
        .rspValid      (rspValid),
        .rspIsRead     (rspIsRead),
        .rspRdData     (rspRdData),
        .rspResp       (rspResp),
        .M_AXI_AWADDR  (awAddr),
        .M_AXI_AWVALID (awValid),
        .M_AXI_AWREADY (awReady),
        .M_AXI_WDATA   (wData),
        .M_AXI_WSTRB   (wStrb),
        .M_AXI_WVALID  (wValid),
        .M_AXI_WREADY  (wReady),
        .M_AXI_BRESP   (bResp),
        .M_AXI_BVALID  (bValid),
        .M_AXI_BREADY  (bReady),
        .M_AXI_ARADDR  (arAddr),
        .M_AXI_ARVALID (arValid),
        .M_AXI_ARREADY (arReady),
        .M_AXI_RDATA   (rData),
        .M_AXI_RRESP   (rResp),
        .M_AXI_RVALID  (rValid),
        .M_AXI_RREADY  (rReady)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count response pulses and ARVALID cycles for whole-sequence assertions
    always @(negedge clk) begin
        if (rspValid) rspCount++;
        if (arValid)  arCount++;
    end

    // Hard time limit so a stuck run still ends with a failure line
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cmdReady"},  32'(cmdReady),  32'd1);
        checkOutput({tag, ".rspValid"},  32'(rspValid),  32'd0);
        checkOutput({tag, ".rspRdData"}, rspRdData,      32'd0);
        checkOutput({tag, ".rspResp"},   32'(rspResp),   32'd0);
        checkOutput({tag, ".rspIsRead"}, 32'(rspIsRead), 32'd0);
        checkOutput({tag, ".AWVALID"},   32'(awValid),   32'd0);
        checkOutput({tag, ".WVALID"},    32'(wValid),    32'd0);
        checkOutput({tag, ".ARVALID"},   32'(arValid),   32'd0);
        checkOutput({tag, ".BREADY"},    32'(bReady),    32'd0);
        checkOutput({tag, ".RREADY"},    32'(rReady),    32'd0);
        checkOutput({tag, ".AWADDR"},    32'(awAddr),    32'd0);
        checkOutput({tag, ".WDATA"},     wData,          32'd0);
        checkOutput({tag, ".WSTRB"},     32'(wStrb),     32'd0);
    endtask

    // Present a command in the cycle ending at t0, then step to the cycle ending at t1
    task automatic issueCmd(input logic wr, input logic rd, input logic [5:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        cmdWr     = wr;
        cmdRd     = rd;
        cmdAddr   = addr;
        cmdWrData = data;
        cmdWstrb  = strb;
        checkOutput("accept.cmdReady", 32'(cmdReady), 32'd1);
        @(negedge clk);
        cmdWr     = 1'b0;
        cmdRd     = 1'b0;
        cmdAddr   = 6'h00;
        cmdWrData = 32'h0;
        cmdWstrb  = 4'h0;
    endtask

    // Minimum-latency transaction with an always-ready slave
    task automatic applyStimulus(input vec_t v, input logic alsoRead);
        issueCmd(v.isWrite, !v.isWrite | alsoRead, v.addr, v.wdata, v.strb);
        checkOutput("t1.AWVALID", 32'(awValid), 32'(v.isWrite));
        checkOutput("t1.WVALID",  32'(wValid),  32'(v.isWrite));
        checkOutput("t1.ARVALID", 32'(arValid), 32'(!v.isWrite));
        checkOutput("t1.cmdReady", 32'(cmdReady), 32'd0);
        if (v.isWrite) begin
            checkOutput("t1.AWADDR", 32'(awAddr), 32'(v.addr));
            checkOutput("t1.WDATA",  wData,       v.wdata);
            checkOutput("t1.WSTRB",  32'(wStrb),  32'(v.strb));
        end else begin
            checkOutput("t1.ARADDR", 32'(arAddr), 32'(v.addr));
        end
        awReady = 1'b1;
        wReady  = 1'b1;
        arReady = 1'b1;
        @(negedge clk);
        awReady = 1'b0;
        wReady  = 1'b0;
        arReady = 1'b0;
        checkOutput("t2.BREADY",  32'(bReady),  32'(v.isWrite));
        checkOutput("t2.RREADY",  32'(rReady),  32'(!v.isWrite));
        checkOutput("t2.AWVALID", 32'(awValid), 32'd0);
        checkOutput("t2.WVALID",  32'(wValid),  32'd0);
        checkOutput("t2.ARVALID", 32'(arValid), 32'd0);
        checkOutput("t2.rspValid", 32'(rspValid), 32'd0);
        bValid = v.isWrite;
        bResp  = v.resp;
        rValid = !v.isWrite;
        rData  = v.rdata;
        rResp  = v.resp;
        @(negedge clk);
        bValid = 1'b0;
        bResp  = 2'b00;
        rValid = 1'b0;
        rData  = 32'h0;
        rResp  = 2'b00;
        checkOutput("t3.rspValid",  32'(rspValid),  32'd1);
        checkOutput("t3.rspIsRead", 32'(rspIsRead), 32'(v.expIsRead));
        checkOutput("t3.rspRdData", rspRdData,      v.expRdData);
        checkOutput("t3.rspResp",   32'(rspResp),   32'(v.expResp));
        checkOutput("t3.BREADY",    32'(bReady),    32'd0);
        checkOutput("t3.RREADY",    32'(rReady),    32'd0);
        checkOutput("t3.cmdReady",  32'(cmdReady),  32'd0);
        @(negedge clk);
        checkOutput("t4.rspValid",  32'(rspValid),  32'd0);
        checkOutput("t4.cmdReady",  32'(cmdReady),  32'd1);
        checkOutput("t4.rspRdData", rspRdData,      v.expRdData);
        checkOutput("t4.rspResp",   32'(rspResp),   32'(v.expResp));
    endtask

    initial begin
        int rspBase;
        int arBase;
        vec_t rdVec;

        //            isWr  addr   wdata         strb  resp   rdata         expRd         expResp expIsRd
        vecs[0] = '{1'b1, 6'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0};
        vecs[1] = '{1'b0, 6'h10, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 1'b1};
        vecs[2] = '{1'b1, 6'h3C, 32'h00000001, 4'h1, 2'b10, 32'h0,        32'h0,        2'b10, 1'b0};
        vecs[3] = '{1'b0, 6'h3F, 32'h0,        4'h0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1'b1};
        vecs[4] = '{1'b1, 6'h00, 32'h0,        4'h0, 2'b11, 32'h0,        32'h0,        2'b11, 1'b0};
        rdVec   = '{1'b0, 6'h24, 32'h0,        4'h0, 2'b01, 32'h0BADF00D, 32'h0BADF00D, 2'b01, 1'b1};

        aresetn   = 1'b0;
        cmdWr     = 1'b0;
        cmdRd     = 1'b0;
        cmdAddr   = 6'h00;
        cmdWrData = 32'h0;
        cmdWstrb  = 4'h0;
        awReady   = 1'b0;
        wReady    = 1'b0;
        arReady   = 1'b0;
        bValid    = 1'b0;
        bResp     = 2'b00;
        rValid    = 1'b0;
        rData     = 32'h0;
        rResp     = 2'b00;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("postReset.cmdReady", 32'(cmdReady), 32'd1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Skewed write: W accepted at t1, AW stalls until t5, B returns at t7
        rspBase = rspCount;
        issueCmd(1'b1, 1'b0, 6'h14, 32'hA5A50001, 4'h3);
        for (int k = 1; k <= 9; k++) begin
            wReady  = (k == 1);
            awReady = (k == 5);
            bValid  = (k == 7);
            bResp   = 2'b00;
            checkOutput($sformatf("skew.t%0d.AWVALID", k), 32'(awValid), 32'(k <= 5));
            checkOutput($sformatf("skew.t%0d.WVALID", k), 32'(wValid), 32'(k == 1));
            checkOutput($sformatf("skew.t%0d.BREADY", k), 32'(bReady), 32'(k == 6 || k == 7));
            checkOutput($sformatf("skew.t%0d.rspValid", k), 32'(rspValid), 32'(k == 8));
            if (k <= 5) begin
                checkOutput($sformatf("skew.t%0d.AWADDR", k), 32'(awAddr), 32'h14);
            end
            if (k == 9) begin
                checkOutput("skew.t9.cmdReady", 32'(cmdReady), 32'd1);
            end
            @(negedge clk);
        end
        bValid  = 1'b0;
        awReady = 1'b0;
        wReady  = 1'b0;
        checkOutput("skew.rspCount", 32'(rspCount - rspBase), 32'd1);

        // Stalled read: AR accepted at t3, R returns at t6 with SLVERR
        rspBase = rspCount;
        issueCmd(1'b0, 1'b1, 6'h10, 32'h0, 4'h0);
        for (int k = 1; k <= 8; k++) begin
            arReady = (k == 3);
            rValid  = (k == 6);
            rData   = (k == 6) ? 32'h12345678 : 32'h0;
            rResp   = (k == 6) ? 2'b10 : 2'b00;
            checkOutput($sformatf("read.t%0d.ARVALID", k), 32'(arValid), 32'(k <= 3));
            checkOutput($sformatf("read.t%0d.RREADY", k), 32'(rReady), 32'(k >= 4 && k <= 6));
            checkOutput($sformatf("read.t%0d.rspValid", k), 32'(rspValid), 32'(k == 7));
            if (k <= 3) begin
                checkOutput($sformatf("read.t%0d.ARADDR", k), 32'(arAddr), 32'h10);
            end
            if (k == 7) begin
                checkOutput("read.t7.rspRdData", rspRdData, 32'h12345678);
                checkOutput("read.t7.rspResp", 32'(rspResp), 32'h2);
                checkOutput("read.t7.rspIsRead", 32'(rspIsRead), 32'd1);
            end
            if (k == 8) begin
                checkOutput("read.t8.cmdReady", 32'(cmdReady), 32'd1);
            end
            @(negedge clk);
        end
        arReady = 1'b0;
        rValid  = 1'b0;
        rData   = 32'h0;
        rResp   = 2'b00;
        checkOutput("read.rspCount", 32'(rspCount - rspBase), 32'd1);

        // Reset while in RD_RESP, with RVALID presented on the reset edge
        issueCmd(1'b0, 1'b1, 6'h20, 32'h0, 4'h0);
        arReady = 1'b1;
        @(negedge clk);
        arReady = 1'b0;
        checkOutput("rstMid.RREADY", 32'(rReady), 32'd1);
        checkOutput("rstMid.heldRdData", rspRdData, 32'h12345678);
        rspBase = rspCount;
        aresetn = 1'b0;
        rValid  = 1'b1;
        rData   = 32'h77777777;
        rResp   = 2'b01;
        @(negedge clk);
        aresetn = 1'b1;
        rValid  = 1'b0;
        rData   = 32'h0;
        rResp   = 2'b00;
        checkResetState("rstMid");
        repeat (2) @(negedge clk);
        checkOutput("rstMid.rspCount", 32'(rspCount - rspBase), 32'd0);
        applyStimulus(rdVec, 1'b0);

        // Simultaneous write and read request: the write wins, no read issued
        rspBase = rspCount;
        arBase  = arCount;
        applyStimulus(vecs[0], 1'b1);
        @(negedge clk);
        checkOutput("both.arCount", 32'(arCount - arBase), 32'd0);
        checkOutput("both.rspCount", 32'(rspCount - rspBase), 32'd1);

        // Commands pulsed while waiting in WR_RESP must be ignored
        rspBase = rspCount;
        arBase  = arCount;
        issueCmd(1'b1, 1'b0, 6'h2C, 32'h0F0F0F0F, 4'hC);
        for (int k = 1; k <= 8; k++) begin
            awReady   = (k == 1);
            wReady    = (k == 1);
            cmdWr     = (k == 2 || k == 3);
            cmdRd     = (k == 3);
            cmdAddr   = (k == 2 || k == 3) ? 6'h3F : 6'h00;
            cmdWrData = (k == 2 || k == 3) ? 32'h55555555 : 32'h0;
            bValid    = (k == 4);
            bResp     = (k == 4) ? 2'b01 : 2'b00;
            if (k >= 2 && k <= 4) begin
                checkOutput($sformatf("busy.t%0d.cmdReady", k), 32'(cmdReady), 32'd0);
                checkOutput($sformatf("busy.t%0d.BREADY", k), 32'(bReady), 32'd1);
                checkOutput($sformatf("busy.t%0d.AWVALID", k), 32'(awValid), 32'd0);
                checkOutput($sformatf("busy.t%0d.ARVALID", k), 32'(arValid), 32'd0);
            end
            if (k == 5) begin
                checkOutput("busy.t5.rspValid", 32'(rspValid), 32'd1);
                checkOutput("busy.t5.rspResp", 32'(rspResp), 32'h1);
                checkOutput("busy.t5.rspIsRead", 32'(rspIsRead), 32'd0);
                checkOutput("busy.t5.cmdReady", 32'(cmdReady), 32'd0);
            end
            if (k == 6) begin
                checkOutput("busy.t6.cmdReady", 32'(cmdReady), 32'd1);
            end
            if (k >= 7) begin
                checkOutput($sformatf("busy.t%0d.AWVALID", k), 32'(awValid), 32'd0);
                checkOutput($sformatf("busy.t%0d.ARVALID", k), 32'(arValid), 32'd0);
            end
            @(negedge clk);
        end
        awReady   = 1'b0;
        wReady    = 1'b0;
        cmdWr     = 1'b0;
        cmdRd     = 1'b0;
        bValid    = 1'b0;
        checkOutput("busy.rspCount", 32'(rspCount - rspBase), 32'd1);
        checkOutput("busy.arCount", 32'(arCount - arBase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
